// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped 64-set x 64-byte data-cache controller.
// Ports: LSU req/resp, 64-bit burst memory bus, data RAM control.
module dcache_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic                  cpu_req_wen,
  input  logic [63:0]           cpu_req_wdata,
  input  logic [3:0]            cpu_req_mask,
  output logic                  cpu_resp_valid,
  output logic [63:0]           cpu_resp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wen,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic [63:0]           mem_wdata,
  output logic                  mem_wlast,
  input  logic                  mem_rvalid,
  input  logic [63:0]           mem_rdata,
  output logic                  ram_wen,
  output logic [5:0]            ram_index,
  output logic [3:0]            ram_write_mask,
  output logic [5:0]            ram_r_offset,
  output logic [5:0]            ram_w_offset,
  output logic [63:0]           ram_data_in,
  input  logic [63:0]           ram_data_out
);
  localparam int TW = ADDR_WIDTH - 12;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB_REQ, WB_DATA, RF_REQ, RF_DATA
  } state_e;

  state_e                state_q;
  logic [2:0]            beat_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [63:0]           wdata_q;
  logic [3:0]            mask_q;
  logic [TW-1:0]         tag_q [64];
  logic [63:0]           valid_q;
  logic [63:0]           dirty_q;

  logic [5:0]    idx;
  logic [TW-1:0] req_tag;
  logic          hit;
  logic          rf_done;

  assign idx     = addr_q[11:6];
  assign req_tag = addr_q[ADDR_WIDTH-1:12];
  assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);
  assign rf_done = (state_q == RF_DATA) && mem_rvalid
                   && (beat_q == 3'd7);

  // Tags need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!rst && rf_done) tag_q[idx] <= req_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cpu_req_valid) begin
            addr_q  <= cpu_req_addr;
            wen_q   <= cpu_req_wen;
            wdata_q <= cpu_req_wdata;
            mask_q  <= cpu_req_mask;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (wen_q) dirty_q[idx] <= 1'b1;
            state_q <= IDLE;
          end else if (dirty_q[idx]) begin
            state_q <= WB_REQ;
          end else begin
            state_q <= RF_REQ;
          end
        end
        WB_REQ: begin
          if (mem_req_ready) begin
            beat_q  <= '0;
            state_q <= WB_DATA;
          end
        end
        WB_DATA: begin
          if (mem_wready) begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'd7) begin
              dirty_q[idx] <= 1'b0;
              state_q      <= RF_REQ;
            end
          end
        end
        RF_REQ: begin
          if (mem_req_ready) begin
            beat_q  <= '0;
            state_q <= RF_DATA;
          end
        end
        RF_DATA: begin
          if (mem_rvalid) begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'd7) begin
              valid_q[idx] <= 1'b1;
              dirty_q[idx] <= 1'b0;
              state_q      <= LOOKUP;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs are forced low while reset is asserted.
  always_comb begin
    cpu_req_ready  = !rst && (state_q == IDLE);
    cpu_resp_valid = !rst && (state_q == LOOKUP) && hit;
    cpu_resp_rdata = ram_data_out;
    mem_req_valid  = !rst && ((state_q == WB_REQ)
                              || (state_q == RF_REQ));
    mem_req_wen    = !rst && (state_q == WB_REQ);
    mem_req_addr   = {req_tag, idx, 6'b0};
    if (state_q == WB_REQ) begin
      mem_req_addr = {tag_q[idx], idx, 6'b0};
    end
    mem_wvalid     = !rst && (state_q == WB_DATA);
    mem_wdata      = ram_data_out;
    mem_wlast      = mem_wvalid && (beat_q == 3'd7);
    ram_index      = idx;
    ram_r_offset   = addr_q[5:0];
    ram_w_offset   = addr_q[5:0];
    ram_write_mask = mask_q;
    ram_data_in    = wdata_q;
    ram_wen        = !rst && (state_q == LOOKUP)
                     && hit && wen_q;
    if (state_q == WB_DATA) begin
      ram_r_offset = {beat_q, 3'b000};
    end
    if (state_q == RF_DATA) begin
      ram_w_offset   = {beat_q, 3'b000};
      ram_write_mask = 4'd8;
      ram_data_in    = mem_rdata;
      ram_wen        = !rst && mem_rvalid;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl.
// Models the data RAM and a burst memory responder.
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic [31:0] cpu_req_addr;
  logic        cpu_req_wen;
  logic [63:0] cpu_req_wdata;
  logic [3:0]  cpu_req_mask;
  logic        cpu_resp_valid;
  logic [63:0] cpu_resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [63:0] mem_wdata;
  logic        mem_wlast;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        ram_wen;
  logic [5:0]  ram_index;
  logic [3:0]  ram_write_mask;
  logic [5:0]  ram_r_offset;
  logic [5:0]  ram_w_offset;
  logic [63:0] ram_data_in;
  logic [63:0] ram_data_out;

  always #5 clk = ~clk;

  dcache_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid),
    .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr),
    .cpu_req_wen(cpu_req_wen),
    .cpu_req_wdata(cpu_req_wdata),
    .cpu_req_mask(cpu_req_mask),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr),
    .mem_wvalid(mem_wvalid),
    .mem_wready(mem_wready),
    .mem_wdata(mem_wdata),
    .mem_wlast(mem_wlast),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .ram_wen(ram_wen),
    .ram_index(ram_index),
    .ram_write_mask(ram_write_mask),
    .ram_r_offset(ram_r_offset),
    .ram_w_offset(ram_w_offset),
    .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  // Data RAM: async read of 8 bytes, sync write of mask bytes.
  logic [7:0] ram [64][64];

  always_comb begin
    ram_data_out = '0;
    for (int b = 0; b < 8; b++) begin
      ram_data_out[8*b +: 8] =
        ram[ram_index][6'(ram_r_offset + 6'(b))];
    end
  end

  always @(posedge clk) begin
    if (ram_wen) begin
      for (int b = 0; b < 8; b++) begin
        if (b < int'(ram_write_mask)) begin
          ram[ram_index][6'(ram_w_offset + 6'(b))]
            <= ram_data_in[8*b +: 8];
        end
      end
    end
  end

  typedef struct {
    logic [63:0] data;
    logic [63:0] care;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
  } mreq_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } wbeat_t;

  resp_t  rq [$];
  mreq_t  mq [$];
  wbeat_t wq [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mem_req_seen = 0;
  int wb_acc = 0;
  int stall_beat = -1;
  int stall_cnt = 0;
  int abort_beats = 8;
  bit aborted = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event want none", name);
  endtask

  function automatic logic [63:0] beat_data(
      input logic [31:0] a, input int k);
    if (a == 32'h8000_0000) begin
      return 64'h1111_1111_1111_1111 * 64'(k + 1);
    end
    return {a, 32'(k)};
  endfunction

  // Monitor: pops the scoreboards whenever the DUT presents output.
  resp_t  re;
  mreq_t  me;
  wbeat_t we;

  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_resp_valid) begin
        if (rq.size() == 0) begin
          miss("resp_unexpected");
        end else begin
          re = rq.pop_front();
          chk("resp_rdata", cpu_resp_rdata & re.care,
              re.data & re.care);
          if (re.cyc >= 0) begin
            chk("resp_latency", 64'(cyc), 64'(re.cyc));
          end
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        mem_req_seen++;
        if (mq.size() == 0) begin
          miss("memreq_unexpected");
        end else begin
          me = mq.pop_front();
          chk("memreq_addr", 64'(mem_req_addr), 64'(me.addr));
          chk("memreq_wen", 64'(mem_req_wen), 64'(me.wen));
        end
      end
      if (mem_wvalid) begin
        if (wq.size() == 0) begin
          miss("wbeat_unexpected");
        end else begin
          we = wq[0];
          chk("wbeat_data", mem_wdata, we.data);
          chk("wbeat_last", 64'(mem_wlast), 64'(we.last));
          if (mem_wready) begin
            void'(wq.pop_front());
            wb_acc++;
          end
        end
      end
    end
  end

  // Memory responder: accepts bursts, stalls and aborts on request.
  logic [31:0] ma;
  logic        mw;
  int          n;

  initial begin
    mem_req_ready = 1'b0;
    mem_wready    = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && mem_req_valid) begin
        ma = mem_req_addr;
        mw = mem_req_wen;
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        if (mw) begin
          n = 0;
          while (n < 8) begin
            if (n == stall_beat && stall_cnt > 0) begin
              mem_wready = 1'b0;
              stall_cnt--;
            end else begin
              mem_wready = 1'b1;
            end
            @(posedge clk);
            if (mem_wready) n++;
            #1;
          end
          mem_wready = 1'b0;
        end else begin
          for (int k = 0; k < 8; k++) begin
            if (k == abort_beats) begin
              aborted = 1'b1;
              break;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = beat_data(ma, k);
            @(posedge clk);
            #1;
          end
          mem_rvalid = 1'b0;
        end
      end
    end
  end

  task automatic cpu_req(input logic [31:0] a,
                         input logic        w,
                         input logic [63:0] wd,
                         input logic [3:0]  m,
                         input logic [63:0] ed,
                         input logic [63:0] care,
                         input bit          lat,
                         input bit          expr);
    int hs;
    bit ok;
    cpu_req_addr  = a;
    cpu_req_wen   = w;
    cpu_req_wdata = wd;
    cpu_req_mask  = m;
    cpu_req_valid = 1'b1;
    ok = 1'b0;
    hs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_req_ready) begin
        ok = 1'b1;
        hs = cyc;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_handshake: got no ready want ready");
    end else if (expr) begin
      rq.push_back('{ed, care, lat ? hs + 1 : -1});
    end
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (rq.size() == 0 && mq.size() == 0
          && wq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got pending=%0d want 0",
               rq.size() + mq.size() + wq.size());
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] ALL = '1;

  int seen0;
  int acc0;
  bit ok_ab;

  initial begin
    cpu_req_valid = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wen   = 1'b0;
    cpu_req_wdata = '0;
    cpu_req_mask  = 4'd8;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(cpu_req_ready), 64'd0);
    chk("rst_memreq", 64'(mem_req_valid), 64'd0);
    chk("rst_wvalid", 64'(mem_wvalid), 64'd0);
    chk("rst_ramwen", 64'(ram_wen), 64'd0);
    chk("rst_resp", 64'(cpu_resp_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(cpu_req_ready), 64'd1);
    @(posedge clk);
    #1;

    // Cold miss, clean refill
    mq.push_back('{32'h8000_0000, 1'b0});
    cpu_req(32'h8000_0010, 1'b0, '0, 4'd8,
            64'h3333_3333_3333_3333, ALL, 1'b0, 1'b1);
    drain();

    // Back-to-back hits, no memory traffic
    seen0 = mem_req_seen;
    cpu_req(32'h8000_0010, 1'b0, '0, 4'd8,
            64'h3333_3333_3333_3333, ALL, 1'b1, 1'b1);
    cpu_req(32'h8000_0010, 1'b0, '0, 4'd8,
            64'h3333_3333_3333_3333, ALL, 1'b1, 1'b1);
    drain();
    chk("hit_no_memreq", 64'(mem_req_seen), 64'(seen0));

    // Byte store then full load
    cpu_req(32'h8000_0013, 1'b1, 64'hAB, 4'd1,
            '0, '0, 1'b1, 1'b1);
    cpu_req(32'h8000_0010, 1'b0, '0, 4'd8,
            64'h3333_3333_AB33_3333, ALL, 1'b1, 1'b1);
    drain();

    // Conflict miss on dirty line, stall at beat 4
    mq.push_back('{32'h8000_0000, 1'b1});
    mq.push_back('{32'h8000_1000, 1'b0});
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        wq.push_back('{64'h3333_3333_AB33_3333, 1'b0});
      end else begin
        wq.push_back('{64'h1111_1111_1111_1111
                       * 64'(k + 1), k == 7});
      end
    end
    stall_beat = 4;
    stall_cnt  = 3;
    acc0 = wb_acc;
    cpu_req(32'h8000_1010, 1'b0, '0, 4'd8,
            64'h8000_1000_0000_0002, ALL, 1'b0, 1'b1);
    drain();
    chk("wb_beat_count", 64'(wb_acc - acc0), 64'd8);
    stall_beat = -1;

    // Reset in the middle of a refill burst
    abort_beats = 5;
    mq.push_back('{32'h8000_0000, 1'b0});
    cpu_req(32'h8000_0010, 1'b0, '0, 4'd8,
            '0, '0, 1'b0, 1'b0);
    ok_ab = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (aborted) begin
        ok_ab = 1'b1;
        break;
      end
    end
    if (!ok_ab) begin
      checks++;
      errors++;
      $display("FAIL abort_wait: got no beat 4 want beat 4");
    end
    #1;
    rst = 1'b1;
    abort_beats = 8;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(cpu_req_ready), 64'd1);
    chk("post_rst_memreq", 64'(mem_req_valid), 64'd0);
    @(posedge clk);
    #1;
    mq.push_back('{32'h8000_0000, 1'b0});
    cpu_req(32'h8000_0010, 1'b0, '0, 4'd8,
            64'h3333_3333_3333_3333, ALL, 1'b0, 1'b1);
    drain();
    chk("final_wq_empty", 64'(wq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped data-cache controller; drives the 64-set × 64-byte cache data RAM (async read, sync byte-masked write) from the LSU side.
- Holds tag/valid/dirty arrays, resolves hit/miss and sequences write-back and refill bursts over a 64-bit memory bus.
- Sits between the LSU (upstream) and the memory bus (downstream).

Parameters:
ADDR_WIDTH, 32, request address width. Offset is [5:0], index is [11:6], tag is [ADDR_WIDTH-1:12].

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_req_valid  in  1  LSU request valid
cpu_req_ready  out  1  controller can accept a request
cpu_req_addr  in  ADDR_WIDTH  byte address, naturally aligned to the access size
cpu_req_wen  in  1  1 = store, 0 = load
cpu_req_wdata  in  64  store data, LSB-justified
cpu_req_mask  in  4  access size in bytes: 1, 2, 4 or 8
cpu_resp_valid  out  1  one-cycle response pulse; no backpressure
cpu_resp_rdata  out  64  load data, byte 0 = addressed byte
mem_req_valid  out  1  burst request valid
mem_req_ready  in  1  burst request accepted
mem_req_wen  out  1  1 = write-back burst, 0 = refill burst
mem_req_addr  out  ADDR_WIDTH  line-aligned address (low 6 bits zero)
mem_wvalid  out  1  write beat valid
mem_wready  in  1  write beat accepted
mem_wdata  out  64  write beat data
mem_wlast  out  1  final write beat (beat 7)
mem_rvalid  in  1  refill beat valid
mem_rdata  in  64  refill beat data
ram_wen  out  1  data RAM write enable
ram_index  out  6  data RAM set index
ram_write_mask  out  4  data RAM write size: 1, 2, 4 or 8
ram_r_offset  out  6  data RAM read byte offset
ram_w_offset  out  6  data RAM write byte offset
ram_data_in  out  64  data RAM write data
ram_data_out  in  64  data RAM read data, combinational from index/r_offset

Behaviour:
- Storage: tag[64], valid[64], dirty[64]. The reset clears all valid and dirty bits in one cycle. Tag contents are don't-care after reset.
- Latched request registers: addr, wen, wdata, mask. Writes occur only on cpu_req_valid && cpu_req_ready.
- beat counter: 3 bits.
- FSM states: IDLE, LOOKUP, WB_REQ, WB_DATA, RF_REQ, RF_DATA.
- Reset values: state=IDLE, beat=0. All valid/wen/last outputs are 0. cpu_req_ready=0 during the reset cycle.
- IDLE:
  - cpu_req_ready=1; this is the only state with ready high.
  - On handshake: latch the request, go to LOOKUP.
- LOOKUP:
  - ram_index = addr[11:6]; ram_r_offset = ram_w_offset = addr[5:0].
  - Hit = valid[idx] && tag[idx] == addr tag.
  - Load hit: cpu_resp_valid=1, cpu_resp_rdata=ram_data_out. Bytes above mask size are don't-care. Go to IDLE.
  - Store hit: ram_wen=1, ram_write_mask=mask, ram_data_in=wdata, dirty[idx]<=1, cpu_resp_valid=1 (rdata don't-care). Go to IDLE.
  - Miss with dirty[idx]: go to WB_REQ. Miss with a clean or invalid line: go to RF_REQ.
- Hit latency: handshake at cycle T, response at T+1. Back-to-back hits give one response every 2 cycles.
- WB_REQ:
  - mem_req_valid=1, mem_req_wen=1, addr={tag[idx], idx, 6'b0}.
  - On mem_req_ready: beat<=0, go to WB_DATA.
- WB_DATA:
  - ram_r_offset={beat,3'b000}; mem_wvalid=1; mem_wdata=ram_data_out; mem_wlast=(beat==7).
  - On mem_wready: beat++. Without wready, data and beat hold.
  - When beat 7 is accepted: dirty[idx]<=0, go to RF_REQ.
- RF_REQ:
  - mem_req_valid=1, mem_req_wen=0, addr={req tag, idx, 6'b0}.
  - On ready: beat<=0, go to RF_DATA. mem_rvalid is ignored in this state.
- RF_DATA:
  - On mem_rvalid: ram_wen=1, ram_write_mask=8, ram_w_offset={beat,3'b000}, ram_data_in=mem_rdata, beat++.
  - The beat counter alone ends the burst; there is no rlast port.
  - When beat 7 is written: tag[idx]<=req tag, valid[idx]<=1, dirty[idx]<=0, go to LOOKUP. The replay then hits and responds as above.
- ram_wen is never asserted outside LOOKUP(store hit) and RF_DATA(rvalid).
- mem_req_valid holds until ready; address and wen are stable while valid.
- Unaligned addresses and mask values not in {1,2,4,8} are unchecked; the RAM threshold semantics apply.
- Reset mid-burst: FSM returns to IDLE, the partial line stays invalid (valid cleared), and the memory side is reset alongside.

Test Plan:
- Reset; load mask=8 at 0x8000_0010 -> RF_REQ addr 0x8000_0000 wen=0; beats k=0..7 carry 0x1111_1111_1111_1111*(k+1); resp rdata=0x3333_3333_3333_3333, no write-back.
- Repeat the same load -> resp exactly 1 cycle after handshake, mem_req_valid stays 0.
- Store mask=1 at 0x8000_0013 data 0xAB, then load mask=8 at 0x8000_0010 -> rdata=0x3333_3333_AB33_3333.
- Load 0x8000_1010 (index 0, new tag) -> WB_REQ addr 0x8000_0000 wen=1; 8 write beats matching the modified line; wlast only on beat 7; then RF_REQ addr 0x8000_1000.
- Hold mem_wready=0 for 3 cycles at beat 4 -> mem_wdata and beat stable; exactly 8 beats accepted in total.
- Assert rst after refill beat 4 -> cpu_req_ready=1 the next cycle; reloading 0x8000_0010 misses and triggers a fresh RF_REQ.
